// File: rtl/dr_byte_loader.sv
// dr_byte_loader: fetches 1-4 bytes from byte-wide memory and assembles them into the 32-bit data register.
// Latency: start in cycle k, N zero-wait bytes in k+1..k+N, done in k+N+1, idle again in k+N+2.
// Backpressure: mem_rd is held with mem_addr stable until mem_valid; TIMEOUT consecutive stalls abort with err.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   i_start           request pulse, only sampled while idle
//   i_addr/i_size     base byte address and (byte count - 1), latched at accept
//   i_sext/i_little   sign-extend and little-endian selects, latched at accept
//   o_busy            high whenever a request is in progress
//   o_done/o_err      one-cycle completion / timeout-abort pulses (never together)
//   o_mem_rd/o_mem_addr, i_mem_valid/i_mem_data   byte memory read handshake
//   o_dr_e/o_dr_funsel/o_dr_i                     data register control and byte input
module dr_byte_loader #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_size,
  input  logic          i_sext,
  input  logic          i_little,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_valid,
  input  logic [7:0]    i_mem_data,
  output logic          o_dr_e,
  output logic [1:0]    o_dr_funsel,
  output logic [7:0]    o_dr_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // Data register function selects.
  localparam logic [1:0] FS_SEXT_LOAD = 2'b00;
  localparam logic [1:0] FS_CLR_LOAD  = 2'b01;
  localparam logic [1:0] FS_SHL_LOAD  = 2'b10;

  // Stall count at which one more stall aborts the request.
  localparam logic [7:0]    LP_WCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] LP_ADDR_ONE  = AW'(1);

  state_t        r_state;
  state_t        w_next_state;

  logic [AW-1:0] r_mem_addr;
  logic [1:0]    r_cnt;        // bytes remaining after the current one
  logic [7:0]    r_wcnt;       // consecutive stall cycles
  logic          r_sext;
  logic          r_little;
  logic          r_first;      // next accepted byte is the first of the request

  logic          w_fetch;
  logic          w_accept;
  logic          w_take;
  logic          w_last;
  logic          w_timeout;
  logic [AW-1:0] w_size_ext;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_accept   = (r_state == S_IDLE) & i_start;
  assign w_take     = w_fetch & i_mem_valid;
  assign w_last     = w_take & (r_cnt == 2'd0);
  // A byte arriving on the final allowed cycle wins over the abort.
  assign w_timeout  = w_fetch & ~i_mem_valid & (r_wcnt == LP_WCNT_LAST);
  assign w_size_ext = AW'(i_size);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_next_state = S_ERR;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    o_err       = (r_state == S_ERR);
    o_mem_rd    = w_fetch;
    // The register captures on the same edge, so a reset cycle must not load it.
    o_dr_e      = w_take & ~rst;
    o_dr_funsel = FS_CLR_LOAD;
    if (o_dr_e) begin
      if (r_first) begin
        o_dr_funsel = r_sext ? FS_SEXT_LOAD : FS_CLR_LOAD;
      end else begin
        o_dr_funsel = FS_SHL_LOAD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request context, address stepping and counters
  // ---------------------------------------------------------------------------
  // The most significant byte is always fetched first so the register can
  // shift left on every later byte: big-endian walks up from addr, little-endian
  // starts at the top byte (addr+size) and walks down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_cnt      <= 2'd0;
      r_wcnt     <= 8'd0;
      r_sext     <= 1'b0;
      r_little   <= 1'b0;
      r_first    <= 1'b0;
    end else if (w_accept) begin
      r_sext     <= i_sext;
      r_little   <= i_little;
      r_cnt      <= i_size;
      r_wcnt     <= 8'd0;
      r_first    <= 1'b1;
      r_mem_addr <= i_little ? (i_addr + w_size_ext) : i_addr;
    end else if (w_take) begin
      r_cnt      <= r_cnt - 2'd1;
      r_wcnt     <= 8'd0;
      r_first    <= 1'b0;
      // Wraps modulo 2^AW in both directions.
      r_mem_addr <= r_little ? (r_mem_addr - LP_ADDR_ONE) : (r_mem_addr + LP_ADDR_ONE);
    end else if (w_fetch) begin
      r_wcnt     <= r_wcnt + 8'd1;
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_dr_i     = i_mem_data;

endmodule
